ahbl_sram_excl: RTL and testbench

- AHB-Lite slave (responder) terminating one downstream port of the bus fabric's N:1 arbiter.
- Backs an on-chip SRAM of DEPTH words and implements the responder side of the exclusive-access sideband (hexcl/hmaster in, hexokay out).
- It holds per-master reservations, so LR/SC-style sequences from multiple harts resolve atomically.
- Zero wait states for all legal transfers; two-cycle ERROR response for illegal ones.

---
 rtl/ahbl_sram_excl.sv | 230 +++++++++++++++++++++++
 tb/tb_ahbl_sram_excl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_excl.sv
// AHB-Lite SRAM responder with per-master exclusive-access reservations.
// Legal transfers complete with zero wait states. Illegal transfers get a
// two-cycle ERROR response. A read of a word that is being written on the
// same edge gets the new bytes through a registered bypass word and mask.
module ahbl_sram_excl #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int DEPTH     = 1024,
  parameter int N_MASTERS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ahbls_hready,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic              ahbls_hexcl,
  input  logic [7:0]        ahbls_hmaster,
  output logic              ahbls_hexokay
);

  localparam int IW = $clog2(DEPTH);
  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [W_ADDR-1:0] BYTE_LIMIT = W_ADDR'(DEPTH * 4);
  localparam logic [8:0]        N_M        = 9'(N_MASTERS);

  typedef enum logic [1:0] {
    RSP_OK   = 2'd0,
    RSP_ERR1 = 2'd1,
    RSP_ERR2 = 2'd2
  } rsp_e;

  // Byte-lane merge: lanes set in mask take upd, others keep base.
  function automatic logic [W_DATA-1:0] merge_lanes(input logic [W_DATA-1:0] base,
                                                    input logic [W_DATA-1:0] upd,
                                                    input logic [3:0]        mask);
    logic [W_DATA-1:0] res;
    res = base;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        res[8*b +: 8] = upd[8*b +: 8];
      end
    end
    return res;
  endfunction

  // SRAM array (not reset)
  logic [W_DATA-1:0] mem_q [DEPTH];

  // Response FSM and registered outputs
  rsp_e              rsp_q;
  logic              hready_resp_q;
  logic              hresp_q;
  logic              hexokay_q;

  // Pending data phase (only a committing write needs to be remembered)
  logic              dp_wr_q;
  logic [IW-1:0]     dp_word_q;
  logic [3:0]        dp_strb_q;

  // Read data register and same-edge write bypass
  logic [W_DATA-1:0] rd_raw_q;
  logic [W_DATA-1:0] byp_word_q;
  logic [3:0]        byp_mask_q;

  // Reservations
  logic [N_MASTERS-1:0] resv_valid_q;
  logic [IW-1:0]        resv_addr_q [N_MASTERS];

  // Address-phase decode
  logic              acc_s;
  logic [IW-1:0]     word_s;
  logic [3:0]        strb_s;
  logic              size_err_s;
  logic              range_err_s;
  logic              bad_s;
  logic              master_ok_s;
  logic [MW-1:0]     mid_s;
  logic              commit_s;
  logic              resv_hit_s;
  logic              exokay_d;
  logic              wr_commit_d;
  logic              unused_s;

  assign unused_s = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0]};

  assign acc_s       = ahbls_hready & ahbls_htrans[1] & (rsp_q != RSP_ERR1);
  assign word_s      = ahbls_haddr[IW+1:2];
  assign master_ok_s = ({1'b0, ahbls_hmaster} < N_M);
  assign mid_s       = ahbls_hmaster[MW-1:0];
  assign bad_s       = size_err_s | range_err_s;
  assign commit_s    = dp_wr_q & ahbls_hready;

  // Transfer size decode: byte strobes and alignment legality
  always_comb begin
    strb_s     = 4'b0000;
    size_err_s = 1'b0;
    case (ahbls_hsize)
      3'd0: begin
        strb_s     = 4'b0001 << ahbls_haddr[1:0];
        size_err_s = 1'b0;
      end
      3'd1: begin
        strb_s     = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
        size_err_s = ahbls_haddr[0];
      end
      3'd2: begin
        strb_s     = 4'b1111;
        size_err_s = (ahbls_haddr[1:0] != 2'b00);
      end
      default: begin
        strb_s     = 4'b0000;
        size_err_s = 1'b1;
      end
    endcase
  end

  // Range check and exclusive outcome, seeing the write committing this edge
  always_comb begin
    range_err_s = (ahbls_haddr >= BYTE_LIMIT);
    if (commit_s && (dp_word_q == word_s)) begin
      resv_hit_s = 1'b0;
    end else begin
      resv_hit_s = resv_valid_q[mid_s] & (resv_addr_q[mid_s] == word_s);
    end
    if (ahbls_hexcl && master_ok_s) begin
      exokay_d = ahbls_hwrite ? resv_hit_s : 1'b1;
    end else begin
      exokay_d = 1'b0;
    end
    if (ahbls_hwrite && (!ahbls_hexcl || exokay_d)) begin
      wr_commit_d = acc_s & ~bad_s;
    end else begin
      wr_commit_d = 1'b0;
    end
  end

  // Response FSM, data-phase capture, read path and reservation tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q         <= RSP_OK;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
      hexokay_q     <= 1'b0;
      dp_wr_q       <= 1'b0;
      dp_word_q     <= '0;
      dp_strb_q     <= 4'b0000;
      rd_raw_q      <= '0;
      byp_word_q    <= '0;
      byp_mask_q    <= 4'b0000;
      resv_valid_q  <= '0;
      for (int m = 0; m < N_MASTERS; m++) begin
        resv_addr_q[m] <= '0;
      end
    end else begin
      case (rsp_q)
        RSP_ERR1: begin
          rsp_q         <= RSP_ERR2;
          hready_resp_q <= 1'b1;
          hresp_q       <= 1'b1;
          hexokay_q     <= 1'b0;
        end
        default: begin
          if (acc_s && bad_s) begin
            rsp_q         <= RSP_ERR1;
            hready_resp_q <= 1'b0;
            hresp_q       <= 1'b1;
            hexokay_q     <= 1'b0;
          end else if (ahbls_hready) begin
            rsp_q         <= RSP_OK;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
            hexokay_q     <= acc_s & exokay_d;
          end
        end
      endcase

      if (ahbls_hready) begin
        dp_wr_q   <= wr_commit_d;
        dp_word_q <= word_s;
        dp_strb_q <= strb_s;
      end

      if (acc_s && !bad_s && !ahbls_hwrite) begin
        rd_raw_q   <= mem_q[word_s];
        byp_word_q <= ahbls_hwdata;
        byp_mask_q <= (commit_s && (dp_word_q == word_s)) ? dp_strb_q : 4'b0000;
      end

      // Commit-edge invalidation first; the address-phase update below is
      // later in bus order and therefore overrides it.
      if (commit_s) begin
        for (int m = 0; m < N_MASTERS; m++) begin
          if (resv_addr_q[m] == dp_word_q) begin
            resv_valid_q[m] <= 1'b0;
          end
        end
      end
      if (acc_s && !bad_s && ahbls_hexcl && master_ok_s) begin
        resv_valid_q[mid_s] <= ~ahbls_hwrite;
        resv_addr_q[mid_s]  <= word_s;
      end
    end
  end

  // SRAM write port: strobed lanes commit at the end of the write data phase
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_strb_q[b]) begin
          mem_q[dp_word_q][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
        end
      end
    end
  end

  assign ahbls_hready_resp = hready_resp_q;
  assign ahbls_hresp       = hresp_q;
  assign ahbls_hexokay     = hexokay_q;
  assign ahbls_hrdata      = merge_lanes(rd_raw_q, byp_word_q, byp_mask_q);

endmodule

// File: tb/tb_ahbl_sram_excl.sv
// Directed bench for ahbl_sram_excl: expectations are queued when an address
// phase is driven and compared when its data phase is visible.
module tb_ahbl_sram_excl;

  logic        clk;
  logic        rst_n;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [2:0]  ahbls_hburst;
  logic [3:0]  ahbls_hprot;
  logic        ahbls_hmastlock;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic        ahbls_hexcl;
  logic [7:0]  ahbls_hmaster;
  logic        ahbls_hexokay;

  typedef struct packed {
    logic        is_err;
    logic        chk_data;
    logic [31:0] data;
    logic        exok;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  logic [31:0] pend_wdata;
  int          n_checks;
  int          n_fail;

  // Single-slave fabric: bus ready is this slave's ready
  assign ahbls_hready = ahbls_hready_resp;

  ahbl_sram_excl #(
    .W_ADDR(32), .W_DATA(32), .DEPTH(1024), .N_MASTERS(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ahbls_hready     (ahbls_hready),
    .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp      (ahbls_hresp),
    .ahbls_haddr      (ahbls_haddr),
    .ahbls_hwrite     (ahbls_hwrite),
    .ahbls_htrans     (ahbls_htrans),
    .ahbls_hsize      (ahbls_hsize),
    .ahbls_hburst     (ahbls_hburst),
    .ahbls_hprot      (ahbls_hprot),
    .ahbls_hmastlock  (ahbls_hmastlock),
    .ahbls_hwdata     (ahbls_hwdata),
    .ahbls_hrdata     (ahbls_hrdata),
    .ahbls_hexcl      (ahbls_hexcl),
    .ahbls_hmaster    (ahbls_hmaster),
    .ahbls_hexokay    (ahbls_hexokay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare the pending data phase (if any), then drive the next address phase.
  task automatic issue(input string tag, input bit act, input bit wr,
                       input logic [31:0] addr, input logic [2:0] size,
                       input bit excl, input logic [7:0] mst, input logic [31:0] wdata,
                       input bit exp_err, input bit chk_data,
                       input logic [31:0] exp_data, input bit exp_exok);
    exp_t  e;
    exp_t  n;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e.is_err) begin
        check({t, "_err1_ready"}, {31'd0, ahbls_hready_resp}, 32'd0);
        check({t, "_err1_resp"},  {31'd0, ahbls_hresp},       32'd1);
        check({t, "_err1_exok"},  {31'd0, ahbls_hexokay},     32'd0);
        ahbls_htrans = 2'b00;
        @(posedge clk); #1;
        check({t, "_err2_ready"}, {31'd0, ahbls_hready_resp}, 32'd1);
        check({t, "_err2_resp"},  {31'd0, ahbls_hresp},       32'd1);
      end else begin
        check({t, "_ready"}, {31'd0, ahbls_hready_resp}, 32'd1);
        check({t, "_resp"},  {31'd0, ahbls_hresp},       32'd0);
        check({t, "_exok"},  {31'd0, ahbls_hexokay},     {31'd0, e.exok});
        if (e.chk_data) begin
          check({t, "_rdata"}, ahbls_hrdata, e.data);
        end
      end
    end
    ahbls_hwdata  = pend_wdata;
    ahbls_htrans  = act ? 2'b10 : 2'b00;
    ahbls_haddr   = addr;
    ahbls_hwrite  = wr;
    ahbls_hsize   = size;
    ahbls_hexcl   = excl;
    ahbls_hmaster = mst;
    if (act) begin
      n.is_err   = exp_err;
      n.chk_data = chk_data;
      n.data     = exp_data;
      n.exok     = exp_exok;
      exp_q.push_back(n);
      tag_q.push_back(tag);
      pend_wdata = wr ? wdata : 32'd0;
    end else begin
      pend_wdata = 32'd0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    pend_wdata      = 32'd0;
    rst_n           = 1'b0;
    ahbls_haddr     = 32'd0;
    ahbls_hwrite    = 1'b0;
    ahbls_htrans    = 2'b00;
    ahbls_hsize     = 3'd2;
    ahbls_hburst    = 3'd0;
    ahbls_hprot     = 4'd0;
    ahbls_hmastlock = 1'b0;
    ahbls_hwdata    = 32'd0;
    ahbls_hexcl     = 1'b0;
    ahbls_hmaster   = 8'd0;

    // Reset values
    #12;
    check("rst_ready", {31'd0, ahbls_hready_resp}, 32'd1);
    check("rst_resp",  {31'd0, ahbls_hresp},       32'd0);
    check("rst_rdata", ahbls_hrdata,               32'd0);
    check("rst_exok",  {31'd0, ahbls_hexokay},     32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    //    tag           act  wr   addr          size  ex   mst    wdata          err  chk  data           exok
    issue("wr_word",    1'b1, 1'b1, 32'h10, 3'd2, 1'b0, 8'd0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0);
    issue("rd_b2b",     1'b1, 1'b0, 32'h10, 3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    issue("wr_byte",    1'b1, 1'b1, 32'h13, 3'd0, 1'b0, 8'd0, 32'hAA000000, 1'b0, 1'b0, 32'h0,        1'b0);
    issue("rd_fwd",     1'b1, 1'b0, 32'h10, 3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'hAAADBEEF, 1'b0);
    // Exclusive pair by master 1 succeeds
    issue("m1_xrd",     1'b1, 1'b0, 32'h40, 3'd2, 1'b1, 8'd1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1);
    issue("m1_xwr",     1'b1, 1'b1, 32'h40, 3'd2, 1'b1, 8'd1, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b1);
    issue("rd_x_ok",    1'b1, 1'b0, 32'h40, 3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0);
    // Intervening write by master 2 breaks master 1's reservation
    issue("m1_xrd2",    1'b1, 1'b0, 32'h40, 3'd2, 1'b1, 8'd1, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1);
    issue("m2_wr",      1'b1, 1'b1, 32'h40, 3'd2, 1'b0, 8'd2, 32'h00000001, 1'b0, 1'b0, 32'h0,        1'b0);
    issue("m1_xwr_bad", 1'b1, 1'b1, 32'h40, 3'd2, 1'b1, 8'd1, 32'h00000002, 1'b0, 1'b0, 32'h0,        1'b0);
    issue("rd_x_fail",  1'b1, 1'b0, 32'h40, 3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'h00000001, 1'b0);
    // Out-of-range and misaligned accesses, then a legal read offered in error cycle 2
    issue("rd_range",   1'b1, 1'b0, 32'h1000, 3'd2, 1'b0, 8'd0, 32'h0,      1'b1, 1'b0, 32'h0,        1'b0);
    issue("rd_half21",  1'b1, 1'b0, 32'h21, 3'd1, 1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0);
    issue("rd_after_e", 1'b1, 1'b0, 32'h10, 3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'hAAADBEEF, 1'b0);
    // Exclusive read from a master without a reservation slot
    issue("m5_xrd",     1'b1, 1'b0, 32'h10, 3'd2, 1'b1, 8'd5, 32'h0,        1'b0, 1'b1, 32'hAAADBEEF, 1'b0);
    // Setup for the reset scenario
    issue("wr_80",      1'b1, 1'b1, 32'h80, 3'd2, 1'b0, 8'd0, 32'h11111111, 1'b0, 1'b0, 32'h0,        1'b0);
    issue("wr_84",      1'b1, 1'b1, 32'h84, 3'd2, 1'b0, 8'd0, 32'h22222222, 1'b0, 1'b0, 32'h0,        1'b0);
    issue("m0_xrd80",   1'b1, 1'b0, 32'h80, 3'd2, 1'b1, 8'd0, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b1);
    issue("wr_84_abrt", 1'b1, 1'b1, 32'h84, 3'd2, 1'b0, 8'd1, 32'h33333333, 1'b0, 1'b0, 32'h0,        1'b0);

    // Reset in the middle of the wr_84_abrt data phase
    ahbls_hwdata = 32'h33333333;
    ahbls_htrans = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ahbls_hready_resp}, 32'd1);
    check("midrst_resp",  {31'd0, ahbls_hresp},       32'd0);
    check("midrst_rdata", ahbls_hrdata,               32'd0);
    check("midrst_exok",  {31'd0, ahbls_hexokay},     32'd0);
    exp_q.delete();
    tag_q.delete();
    pend_wdata = 32'd0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    issue("m0_xwr_rst", 1'b1, 1'b1, 32'h80, 3'd2, 1'b1, 8'd0, 32'h99999999, 1'b0, 1'b0, 32'h0,        1'b0);
    issue("rd_80_post", 1'b1, 1'b0, 32'h80, 3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b0);
    issue("rd_84_post", 1'b1, 1'b0, 32'h84, 3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 32'h22222222, 1'b0);
    issue("idle_flush", 1'b0, 1'b0, 32'h0,  3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0);
    issue("idle_end",   1'b0, 1'b0, 32'h0,  3'd2, 1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
